// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker: turns 3-byte PS/2 mouse packets into a clamped
// absolute cursor position, button state and click pulses.
// Two-stage pipeline: stage 1 decodes/validates deltas, stage 2 applies them.
// Optional feature macro: MOUSE_ACCEL_EN (doubles deltas with |d| > ACCEL_THRESH).
module mouse_position_tracker #(
    parameter int POS_W        = 8,
    parameter int LIMIT_X      = 160,
    parameter int LIMIT_Y      = 120,
    parameter int DELTA_SHIFT  = 0,
    parameter int INVERT_Y     = 1,
    parameter int ACCEL_THRESH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PKT_VALID,
    input  logic [7:0]       STATUS,
    input  logic [7:0]       DX,
    input  logic [7:0]       DY,
    input  logic             RECENTRE,
    output logic [POS_W-1:0] POS_X,
    output logic [POS_W-1:0] POS_Y,
    output logic [2:0]       BUTTONS,
    output logic [2:0]       CLICK,
    output logic             POS_VALID,
    output logic             SYNC_ERR,
    output logic [7:0]       PKT_CNT
);

    // Deltas are carried as 10-bit signed so a doubled 9-bit delta still fits.
    localparam int D_W = 10;
    // Sum width has one bit beyond POS_W+2 so a doubled delta added to a
    // full-scale position can never wrap before clamping.
    localparam int SUM_W = POS_W + 3;

    localparam logic [POS_W-1:0]        CEN_X = POS_W'(LIMIT_X / 2);
    localparam logic [POS_W-1:0]        CEN_Y = POS_W'(LIMIT_Y / 2);
    localparam logic signed [SUM_W-1:0] MAX_X = SUM_W'(LIMIT_X - 1);
    localparam logic signed [SUM_W-1:0] MAX_Y = SUM_W'(LIMIT_Y - 1);

    typedef struct packed {
        logic [D_W-1:0] dx;
        logic [D_W-1:0] dy;
        logic [2:0]     btn;
    } s1_t;

    s1_t                      s1, s1_next;
    logic                     s1_vld;
    logic [8:0]               dx9, dy9;
    logic signed [D_W-1:0]    dx_a, dy_a;
    logic signed [SUM_W-1:0]  cur_x, cur_y, del_x, del_y, sum_x, sum_y;
    logic [POS_W-1:0]         nx, ny;

`ifdef MOUSE_ACCEL_EN
    localparam logic signed [D_W-1:0] THR = D_W'(ACCEL_THRESH);
`else
    localparam int unused_accel_thresh = ACCEL_THRESH;
`endif

    // Stage-1 decode: sign-extend, zero on overflow, optional accel, speed shift.
    always_comb begin
        dx9  = STATUS[6] ? 9'd0 : {STATUS[4], DX};
        dy9  = STATUS[7] ? 9'd0 : {STATUS[5], DY};
        dx_a = {dx9[8], dx9};
        dy_a = {dy9[8], dy9};
`ifdef MOUSE_ACCEL_EN
        if (dx_a > THR || dx_a < -THR) dx_a = dx_a <<< 1;
        if (dy_a > THR || dy_a < -THR) dy_a = dy_a <<< 1;
`endif
        s1_next.dx  = dx_a >>> DELTA_SHIFT;
        s1_next.dy  = dy_a >>> DELTA_SHIFT;
        s1_next.btn = STATUS[2:0];
    end

    // Stage-2 arithmetic: signed add against the live position, then clamp per axis.
    always_comb begin
        cur_x = SUM_W'({1'b0, POS_X});
        cur_y = SUM_W'({1'b0, POS_Y});
        del_x = {{(SUM_W-D_W){s1.dx[D_W-1]}}, s1.dx};
        del_y = {{(SUM_W-D_W){s1.dy[D_W-1]}}, s1.dy};
        sum_x = cur_x + del_x;
        sum_y = (INVERT_Y != 0) ? (cur_y - del_y) : (cur_y + del_y);

        if (sum_x < 0)          nx = '0;
        else if (sum_x > MAX_X) nx = MAX_X[POS_W-1:0];
        else                    nx = sum_x[POS_W-1:0];

        if (sum_y < 0)          ny = '0;
        else if (sum_y > MAX_Y) ny = MAX_Y[POS_W-1:0];
        else                    ny = sum_y[POS_W-1:0];
    end

    // Pipeline registers and outputs; RECENTRE wins over a packet in stage 2.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1        <= '0;
            s1_vld    <= 1'b0;
            POS_X     <= CEN_X;
            POS_Y     <= CEN_Y;
            BUTTONS   <= '0;
            CLICK     <= '0;
            POS_VALID <= 1'b0;
            SYNC_ERR  <= 1'b0;
            PKT_CNT   <= '0;
        end else begin
            SYNC_ERR  <= PKT_VALID & ~STATUS[3];
            s1_vld    <= PKT_VALID & STATUS[3];
            if (PKT_VALID) s1 <= s1_next;
            CLICK     <= '0;
            POS_VALID <= 1'b0;
            if (RECENTRE) begin
                POS_X <= CEN_X;
                POS_Y <= CEN_Y;
            end else if (s1_vld) begin
                POS_X     <= nx;
                POS_Y     <= ny;
                BUTTONS   <= s1.btn;
                CLICK     <= s1.btn & ~BUTTONS;
                POS_VALID <= 1'b1;
                PKT_CNT   <= PKT_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Self-checking bench for mouse_position_tracker: directed packet scenarios
// followed by randomized traffic, all compared to a cycle-level reference model.
module tb_mouse_position_tracker;

    localparam int LX    = 160;
    localparam int LY    = 120;
    localparam int SHIFT = 0;
    localparam int THR   = 8;

    logic       CLK = 1'b0;
    logic       RESET, PKT_VALID, RECENTRE;
    logic [7:0] STATUS, DX, DY;
    logic [7:0] POS_X, POS_Y, PKT_CNT;
    logic [2:0] BUTTONS, CLICK;
    logic       POS_VALID, SYNC_ERR;

    int n_chk  = 0;
    int n_pass = 0;

    // reference state
    int   m_x, m_y, m_cnt;
    logic [2:0] m_btn, m_click;
    bit   m_pv, m_serr;
    bit   p_ok;
    int   p_dx, p_dy;
    logic [2:0] p_btn;

    mouse_position_tracker dut (
        .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .STATUS(STATUS),
        .DX(DX), .DY(DY), .RECENTRE(RECENTRE), .POS_X(POS_X), .POS_Y(POS_Y),
        .BUTTONS(BUTTONS), .CLICK(CLICK), .POS_VALID(POS_VALID),
        .SYNC_ERR(SYNC_ERR), .PKT_CNT(PKT_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Signed delta as the mouse means it, after overflow, accel and speed divider.
    function automatic int delta(input logic [7:0] st, input logic [7:0] d, input bit is_y);
        int v;
        bit ov, sg;
        ov = is_y ? st[7] : st[6];
        sg = is_y ? st[5] : st[4];
        v  = ov ? 0 : (sg ? int'(d) - 256 : int'(d));
`ifdef MOUSE_ACCEL_EN
        if (v > THR || v < -THR) v = v * 2;
`endif
        return v >>> SHIFT;
    endfunction

    function automatic int clamp(input int v, input int lim);
        if (v < 0) return 0;
        if (v > lim - 1) return lim - 1;
        return v;
    endfunction

    // One clock: drive inputs, advance model, compare every output.
    task automatic step(input bit pv, input logic [7:0] st, input logic [7:0] dx,
                        input logic [7:0] dy, input bit rc, input bit rst);
        PKT_VALID = pv; STATUS = st; DX = dx; DY = dy; RECENTRE = rc; RESET = rst;
        @(posedge CLK);
        #1;
        if (rst) begin
            m_x = LX / 2; m_y = LY / 2; m_cnt = 0;
            m_btn = 0; m_click = 0; m_pv = 0; m_serr = 0; p_ok = 0;
        end else begin
            m_serr  = pv && !st[3];
            m_pv    = 0;
            m_click = 0;
            if (rc) begin
                m_x = LX / 2; m_y = LY / 2;
            end else if (p_ok) begin
                m_x     = clamp(m_x + p_dx, LX);
                m_y     = clamp(m_y - p_dy, LY);
                m_click = p_btn & ~m_btn;
                m_btn   = p_btn;
                m_cnt   = (m_cnt + 1) % 256;
                m_pv    = 1;
            end
            p_ok  = pv && st[3];
            p_dx  = delta(st, dx, 0);
            p_dy  = delta(st, dy, 1);
            p_btn = st[2:0];
        end
        chk("pos_x",     POS_X,     m_x);
        chk("pos_y",     POS_Y,     m_y);
        chk("buttons",   BUTTONS,   m_btn);
        chk("click",     CLICK,     m_click);
        chk("pos_valid", POS_VALID, m_pv);
        chk("sync_err",  SYNC_ERR,  m_serr);
        chk("pkt_cnt",   PKT_CNT,   m_cnt);
    endtask

    task automatic pkt(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy);
        step(1, st, dx, dy, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 8'h00, 8'h00, 8'h00, 0, 1);
        step(0, 8'h00, 8'h00, 8'h00, 0, 1);
    endtask

    initial begin
        p_dx = 0; p_dy = 0; p_btn = 0; p_ok = 0;
        do_reset();
        chk("reset_x", POS_X, 80);
        chk("reset_y", POS_Y, 60);
        chk("reset_cnt", PKT_CNT, 0);

        // basic move
        pkt(8'h08, 8'h05, 8'h03);
        idle(1);
        chk("t2_valid", POS_VALID, 1);
        chk("t2_x", POS_X, 85);
        chk("t2_y", POS_Y, 57);
        chk("t2_cnt", PKT_CNT, 1);

        // clamp at both X edges
        do_reset();
        pkt(8'h18, 8'h80, 8'h00);
        pkt(8'h08, 8'h7F, 8'h00);
        pkt(8'h08, 8'h7F, 8'h00);
        idle(2);
        chk("t3_x_hi", POS_X, 159);

        // X overflow ignored; sync error rejected
        do_reset();
        pkt(8'h48, 8'h10, 8'h02);
        idle(2);
        chk("t4_x", POS_X, 80);
        chk("t4_y", POS_Y, 58);
        pkt(8'h00, 8'h10, 8'h10);
        chk("t4_serr", SYNC_ERR, 1);
        idle(2);
        chk("t4_cnt", PKT_CNT, 1);

        // clicks back-to-back
        pkt(8'h09, 8'h00, 8'h00);
        pkt(8'h0B, 8'h00, 8'h00);
        chk("t5_click0", CLICK, 3'b001);
        pkt(8'h08, 8'h00, 8'h00);
        chk("t5_click1", CLICK, 3'b010);
        idle(1);
        chk("t5_click2", CLICK, 3'b000);
        chk("t5_btn2", BUTTONS, 3'b000);

        // recentre drops the packet in stage 2
        do_reset();
        pkt(8'h08, 8'h01, 8'h00);
        pkt(8'h08, 8'h01, 8'h00);
        step(1, 8'h08, 8'h01, 8'h00, 1, 0);
        chk("t6_x_rc", POS_X, 80);
        idle(1);
        chk("t6_x_after", POS_X, 81);
        idle(1);

        // acceleration threshold
        do_reset();
        pkt(8'h08, 8'h0A, 8'h00);
        idle(1);
`ifdef MOUSE_ACCEL_EN
        chk("accel_x", POS_X, 100);
`else
        chk("accel_x", POS_X, 90);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] st;
            st = 8'($urandom);
            if ($urandom_range(0, 9) != 0) st[3] = 1'b1;
            step($urandom_range(0, 1) == 1, st, 8'($urandom), 8'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
